ifmap_loader: RTL and testbench



---
 rtl/bnn_pkg.sv | 30 +++
 rtl/ifmap_loader_if.sv | 41 ++++
 rtl/ifmap_pos_counter.sv | 64 ++++++
 rtl/ifmap_loader.sv | 145 ++++++++++++++
 tb/tb_ifmap_loader.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bnn_pkg
//  Purpose  : Shared types and constants for the input-feature-map loader
//             and its position counter.
//  Contents : state_t      - loader FSM state (IDLE, LOAD, ERR)
//             MAX_CHANNEL  - number of channel banks
//             IFMAP_ADDR_W - bank address width
//             stored_side  - side of the stored (optionally padded) image
//  Revision : 1.0 - initial release
// ============================================================================
package bnn_pkg;

  localparam int MAX_CHANNEL  = 32;
  localparam int IFMAP_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ERR  = 2'd2
  } state_t;

  // Stored side D = W + 2*pad, one bit wider than W so W=65535 with
  // padding cannot wrap.
  function automatic logic [16:0] stored_side(input logic [15:0] w, input logic pad);
    return {1'b0, w} + (pad ? 17'd2 : 17'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifmap_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : ifmap_loader_if
//  Purpose  : Pixel-stream input and bank-write output bus of the loader.
//  Signals  : s_data/s_valid/s_ready          - incoming pixel stream
//             wr_en/wr_addr/wr_data           - bank write strobe/addr/data
//             channel_en                      - one-hot bank select
//             first_channel/last_channel      - channel position flags
//  Modports : master - the loader; slave - the stream source / bank sink
//  Revision : 1.0 - initial release
// ============================================================================
interface ifmap_loader_if
  import bnn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = IFMAP_ADDR_W,
  parameter int N_BANK = MAX_CHANNEL
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [N_BANK-1:0] channel_en;
  logic              first_channel;
  logic              last_channel;

  modport master (
    input  s_data, s_valid,
    output s_ready, wr_en, wr_addr, wr_data, channel_en, first_channel, last_channel
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready, wr_en, wr_addr, wr_data, channel_en, first_channel, last_channel
  );

endinterface
`default_nettype wire

// File: rtl/ifmap_pos_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ifmap_pos_counter
//  Purpose  : Walks col/row over 0..side-1 and a linear bank address for one
//             channel; flags border positions and the last position.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             clear           - force counters to zero (new load)
//             issue           - advance to the next position
//             side, pad       - stored side and padding enable (latched)
//             addr            - bank address of the current position
//             border          - current position is in the zero border
//             end_of_channel  - current position is the last of a channel
//  Revision : 1.0 - initial release
// ============================================================================
module ifmap_pos_counter
  import bnn_pkg::*;
#(
  parameter int ADDR_W = IFMAP_ADDR_W
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              clear,
  input  wire              issue,
  input  wire  [16:0]      side,
  input  wire              pad,
  output logic [ADDR_W-1:0] addr,
  output logic             border,
  output logic             end_of_channel
);

  logic [16:0] col;
  logic [16:0] row;
  logic [16:0] last_idx;

  assign last_idx       = side - 17'd1;
  assign end_of_channel = (col == last_idx) && (row == last_idx);
  assign border         = pad && ((col == 17'd0) || (row == 17'd0) ||
                                  (col == last_idx) || (row == last_idx));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if (issue) begin
      if (col == last_idx) begin
        col <= '0;
        if (row == last_idx) begin
          // Every bank starts at address 0, so wrap for the next channel.
          row  <= '0;
          addr <= '0;
        end else begin
          row  <= row + 17'd1;
          addr <= addr + ADDR_W'(1);
        end
      end else begin
        col  <= col + 17'd1;
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifmap_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ifmap_loader
//  Purpose  : Writes a channel-major pixel stream into the banked input
//             feature-map buffers, inserting a zero border when padding is
//             enabled, and pulses done when the whole map is stored.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             start                    - begin a load (sampled in IDLE)
//             image_size, number_channel, padding - load configuration
//             bus (master)             - pixel stream in, bank writes out
//             busy                     - load in progress
//             done                     - one-cycle completion pulse
//             cfg_err                  - pulses with done on bad config
//  Revision : 1.0 - initial release
// ============================================================================
module ifmap_loader
  import bnn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = IFMAP_ADDR_W,
  parameter int N_BANK = MAX_CHANNEL
) (
  input  wire          clk,
  input  wire          rst,
  input  wire          start,
  input  wire  [15:0]  image_size,
  input  wire  [5:0]   number_channel,
  input  wire          padding,
  ifmap_loader_if.master bus,
  output logic         busy,
  output logic         done,
  output logic         cfg_err
);

  localparam int CH_W = $clog2(MAX_CHANNEL);

  state_t            state;
  logic [16:0]       cfg_side;
  logic              cfg_pad;
  logic [CH_W-1:0]   cfg_last;
  logic [CH_W-1:0]   ch;

  logic [16:0]       side_in;
  logic [33:0]       area_in;
  logic              cfg_bad;
  logic              start_ok;
  logic              issue;
  logic              border;
  logic              end_of_channel;
  logic [ADDR_W-1:0] addr;

  // Full-width D*D so an oversized image cannot alias into a legal one.
  assign side_in  = stored_side(image_size, padding);
  assign area_in  = {17'd0, side_in} * {17'd0, side_in};
  assign cfg_bad  = (number_channel == 6'd0) ||
                    (number_channel > 6'(MAX_CHANNEL)) ||
                    (image_size == 16'd0) ||
                    (area_in > (34'd1 << ADDR_W));
  assign start_ok = (state == IDLE) && start && !cfg_bad;

  // Border positions issue on their own; interior ones wait for a beat.
  assign issue       = busy && (border || bus.s_valid);
  assign bus.s_ready = busy && !border;

  ifmap_pos_counter #(
    .ADDR_W (ADDR_W)
  ) u_pos (
    .clk            (clk),
    .rst            (rst),
    .clear          (start_ok),
    .issue          (issue),
    .side           (cfg_side),
    .pad            (cfg_pad),
    .addr           (addr),
    .border         (border),
    .end_of_channel (end_of_channel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      cfg_err           <= 1'b0;
      cfg_side          <= '0;
      cfg_pad           <= 1'b0;
      cfg_last          <= '0;
      ch                <= '0;
      bus.wr_en         <= 1'b0;
      bus.wr_addr       <= '0;
      bus.wr_data       <= '0;
      bus.channel_en    <= '0;
      bus.first_channel <= 1'b0;
      bus.last_channel  <= 1'b0;
    end else begin
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      bus.wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              state   <= ERR;
              done    <= 1'b1;
              cfg_err <= 1'b1;
            end else begin
              state    <= LOAD;
              busy     <= 1'b1;
              cfg_side <= side_in;
              cfg_pad  <= padding;
              cfg_last <= CH_W'(number_channel - 6'd1);
              ch       <= '0;
            end
          end
        end
        LOAD: begin
          if (issue) begin
            bus.wr_en         <= 1'b1;
            bus.wr_addr       <= addr;
            bus.wr_data       <= border ? '0 : bus.s_data;
            bus.channel_en    <= N_BANK'(1) << ch;
            bus.first_channel <= (ch == '0);
            bus.last_channel  <= (ch == cfg_last);
            if (end_of_channel) begin
              if (ch == cfg_last) begin
                // done lands with the final write; a new start is
                // accepted in that same cycle.
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
                ch    <= '0;
              end else begin
                ch <= ch + CH_W'(1);
              end
            end
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifmap_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifmap_loader
//  Purpose  : Self-checking bench for ifmap_loader. A reference model builds
//             the expected write list from the load configuration and the
//             pixels fed in; each scenario task compares against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifmap_loader;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;
  localparam int N_BANK = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] image_size;
  logic [5:0]  number_channel;
  logic        padding;
  logic        busy;
  logic        done;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  // Packed write record: {addr[16], data[8], channel_en[32], first, last}
  logic [57:0] act_w[$];
  logic [57:0] exp_w[$];
  logic [7:0]  src[$];

  ifmap_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_BANK(N_BANK)) bus ();

  ifmap_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .N_BANK (N_BANK)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .image_size     (image_size),
    .number_channel (number_channel),
    .padding        (padding),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic fill_src(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: every channel stores a D x D image at addresses r*D+c,
  // border pixels zero, interior pixels taken from the stream in order.
  task automatic build_expected(input int w, input int c, input bit pad);
    int d, k;
    logic [7:0]  px;
    logic [31:0] chen;
    bit b;
    d = w + (pad ? 2 : 0);
    k = 0;
    exp_w.delete();
    for (int ch = 0; ch < c; ch++)
      for (int r = 0; r < d; r++)
        for (int cl = 0; cl < d; cl++) begin
          b = pad && (r == 0 || r == d - 1 || cl == 0 || cl == d - 1);
          if (b) px = 8'h00;
          else begin px = src[k]; k++; end
          chen = 32'd1 << ch;
          exp_w.push_back({16'(r * d + cl), px, chen, ch == 0, ch == c - 1});
        end
  endtask

  // Starts a load at the current negedge and runs until done, recording
  // writes. Returns at the negedge where done is seen, so an immediate
  // second call starts during the done cycle.
  // vmode: 0 = s_valid always high, 1 = every other cycle, 2 = random.
  task automatic do_load(input int w, input int c, input bit pad, input int vmode,
                         input bit poke, output int done_iter, output bit err_seen,
                         output bit busy_at_done, output int ready_cnt, output int busy_cnt);
    int idx, max_it;
    bit v;
    act_w.delete();
    idx = 0; done_iter = 0; err_seen = 0; busy_at_done = 0; ready_cnt = 0; busy_cnt = 0;
    max_it = 8 * c * (w + 2) * (w + 2) + 50;
    if (max_it > 4000) max_it = 4000;
    image_size = 16'(w); number_channel = 6'(c); padding = pad;
    start = 1'b1; bus.s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int it = 1; it <= max_it; it++) begin
      if (bus.wr_en)
        act_w.push_back({bus.wr_addr, bus.wr_data, bus.channel_en,
                         bus.first_channel, bus.last_channel});
      if (bus.s_ready) ready_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_iter = it; err_seen = cfg_err; busy_at_done = busy;
        break;
      end
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? bit'(it % 2) : bit'($urandom_range(0, 1));
      if (idx >= src.size()) v = 1'b0;
      bus.s_valid = v;
      bus.s_data  = v ? src[idx] : 8'($urandom_range(0, 255));
      if (v && bus.s_ready) idx++;
      if (poke) begin
        start = 1'b1;
        image_size = 16'($urandom_range(0, 65535));
        number_channel = 6'($urandom_range(0, 63));
        padding = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start = 1'b0; bus.s_valid = 1'b0;
    if (done_iter == 0) begin
      checks++; errors++;
      $display("FAIL load timeout: no done within %0d cycles (W=%0d C=%0d pad=%0d)", max_it, w, c, pad);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0;
    image_size = '0; number_channel = '0; padding = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.channel_en, bus.first_channel,
         bus.last_channel, busy, done, cfg_err, bus.s_ready} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got wr_en=%b addr=%h data=%h chen=%h busy=%b done=%b err=%b rdy=%b, required all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.channel_en, busy, done, cfg_err, bus.s_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int di, rc, bc; bit es, bd;
    src.delete();
    src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33); src.push_back(8'h44);
    build_expected(2, 1, 1'b0);
    do_load(2, 1, 1'b0, 0, 1'b0, di, es, bd, rc, bc);
    checks++;
    if (act_w.size() !== exp_w.size()) begin errors++; $display("FAIL basic count: got %0d required %0d", act_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
      checks++;
      if (act_w[i] !== exp_w[i]) begin errors++; $display("FAIL basic write %0d: got %h required %h", i, act_w[i], exp_w[i]); end
    end
    checks++;
    if (di !== 5 || es !== 1'b0 || bd !== 1'b0) begin
      errors++; $display("FAIL basic done: got iter=%0d err=%b busy=%b, required 5/0/0", di, es, bd);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL basic done pulse width: got done=%b one cycle later, required 0", done); end
  endtask

  task automatic test_padded;
    int di, rc, bc; bit es, bd;
    fill_src(4);
    build_expected(2, 1, 1'b1);
    do_load(2, 1, 1'b1, 0, 1'b0, di, es, bd, rc, bc);
    checks++;
    if (act_w.size() !== exp_w.size()) begin errors++; $display("FAIL padded count: got %0d required %0d", act_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
      checks++;
      if (act_w[i] !== exp_w[i]) begin errors++; $display("FAIL padded write %0d: got %h required %h", i, act_w[i], exp_w[i]); end
    end
    checks++;
    if (di !== 17 || bc !== 16 || rc !== 4) begin
      errors++; $display("FAIL padded timing: got done_iter=%0d busy=%0d ready=%0d, required 17/16/4", di, bc, rc);
    end
    @(negedge clk);
  endtask

  task automatic test_channels;
    int di, rc, bc; bit es, bd;
    fill_src(3);
    build_expected(1, 3, 1'b0);
    do_load(1, 3, 1'b0, 0, 1'b0, di, es, bd, rc, bc);
    checks++;
    if (act_w.size() !== exp_w.size()) begin errors++; $display("FAIL channels count: got %0d required %0d", act_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
      checks++;
      if (act_w[i] !== exp_w[i]) begin errors++; $display("FAIL channels write %0d: got %h required %h", i, act_w[i], exp_w[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_toggle;
    int di, rc, bc; bit es, bd;
    fill_src(8);
    build_expected(2, 2, 1'b0);
    do_load(2, 2, 1'b0, 1, 1'b0, di, es, bd, rc, bc);
    checks++;
    if (act_w.size() !== exp_w.size()) begin errors++; $display("FAIL toggle count: got %0d required %0d", act_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
      checks++;
      if (act_w[i] !== exp_w[i]) begin errors++; $display("FAIL toggle write %0d: got %h required %h", i, act_w[i], exp_w[i]); end
    end
    checks++;
    if (di !== 16) begin errors++; $display("FAIL toggle done: got iter %0d required 16", di); end
    @(negedge clk);
  endtask

  task automatic test_cfg_err;
    int tc[4] = '{0, 33, 1, 2};
    int tw[4] = '{2, 2, 256, 0};
    bit tp[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int di, rc, bc; bit es, bd;
    for (int t = 0; t < 4; t++) begin
      src.delete();
      do_load(tw[t], tc[t], tp[t], 0, 1'b0, di, es, bd, rc, bc);
      checks++;
      if (di !== 1 || es !== 1'b1 || act_w.size() !== 0 || rc !== 0 || bc !== 0) begin
        errors++;
        $display("FAIL cfg_err case %0d: got done_iter=%0d cfg_err=%b writes=%0d ready=%0d busy=%0d, required 1/1/0/0/0",
                 t, di, es, act_w.size(), rc, bc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int di, rc, bc; bit es, bd;
    fill_src(4);
    do_load(2, 1, 1'b0, 0, 1'b0, di, es, bd, rc, bc);
    fill_src(9);
    build_expected(3, 1, 1'b1);
    do_load(3, 1, 1'b1, 0, 1'b0, di, es, bd, rc, bc);
    checks++;
    if (act_w.size() !== exp_w.size()) begin errors++; $display("FAIL b2b count: got %0d required %0d", act_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
      checks++;
      if (act_w[i] !== exp_w[i]) begin errors++; $display("FAIL b2b write %0d: got %h required %h", i, act_w[i], exp_w[i]); end
    end
    checks++;
    if (di !== 26) begin errors++; $display("FAIL b2b done: got iter %0d required 26", di); end
    @(negedge clk);
  endtask

  task automatic test_start_busy;
    int di, rc, bc; bit es, bd;
    fill_src(18);
    build_expected(3, 2, 1'b1);
    do_load(3, 2, 1'b1, 0, 1'b1, di, es, bd, rc, bc);
    checks++;
    if (act_w.size() !== exp_w.size()) begin errors++; $display("FAIL start_busy count: got %0d required %0d", act_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
      checks++;
      if (act_w[i] !== exp_w[i]) begin errors++; $display("FAIL start_busy write %0d: got %h required %h", i, act_w[i], exp_w[i]); end
    end
    checks++;
    if (di !== 51 || es !== 1'b0) begin errors++; $display("FAIL start_busy done: got iter %0d err %b required 51/0", di, es); end
    @(negedge clk);
  endtask

  task automatic test_random;
    int w, c, di, rc, bc; bit pad, es, bd;
    for (int n = 0; n < 8; n++) begin
      w = $urandom_range(1, 5);
      c = (n == 0) ? 32 : $urandom_range(1, 4);
      if (n == 0) w = 1;
      pad = 1'($urandom_range(0, 1));
      fill_src(c * w * w);
      build_expected(w, c, pad);
      do_load(w, c, pad, 2, 1'b0, di, es, bd, rc, bc);
      checks++;
      if (act_w.size() !== exp_w.size() || es !== 1'b0) begin
        errors++; $display("FAIL random %0d count: got %0d err=%b required %0d err=0", n, act_w.size(), es, exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
        checks++;
        if (act_w[i] !== exp_w[i]) begin errors++; $display("FAIL random %0d write %0d: got %h required %h", n, i, act_w[i], exp_w[i]); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midload;
    int di, rc, bc; bit es, bd;
    image_size = 16'd3; number_channel = 6'd2; padding = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; bus.s_valid = 1'b1; bus.s_data = 8'hA5;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.channel_en, bus.first_channel,
         bus.last_channel, busy, done, cfg_err, bus.s_ready} !== '0) begin
      errors++;
      $display("FAIL midload reset outputs: got wr_en=%b addr=%h data=%h chen=%h busy=%b done=%b rdy=%b, required all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.channel_en, busy, done, bus.s_ready);
    end
    rst = 1'b0; bus.s_valid = 1'b0;
    @(negedge clk);
    fill_src(18);
    build_expected(3, 2, 1'b0);
    do_load(3, 2, 1'b0, 0, 1'b0, di, es, bd, rc, bc);
    checks++;
    if (act_w.size() !== exp_w.size()) begin errors++; $display("FAIL restart count: got %0d required %0d", act_w.size(), exp_w.size()); end
    for (int i = 0; i < exp_w.size() && i < act_w.size(); i++) begin
      checks++;
      if (act_w[i] !== exp_w[i]) begin errors++; $display("FAIL restart write %0d: got %h required %h", i, act_w[i], exp_w[i]); end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padded();
    test_channels();
    test_toggle();
    test_cfg_err();
    test_back_to_back();
    test_start_busy();
    test_random();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
